// File: rtl/cdc_pkg.sv
// Shared types and the round-robin pick helper for the source-side CDC
// handshake arbiter.
package cdc_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_state_e;

  // The helper works on a fixed maximum width; callers zero-extend into it.
  localparam int RR_MAX = 32;

  // First set bit of valid at or after ptr, wrapping modulo n. Returns 0 when
  // nothing is valid; callers only act on the result when some bit is set.
  function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [4:0]        ptr,
                                         input logic [5:0]        n);
    logic [5:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < int'(n) && !found) begin
        idx = {1'b0, ptr} + 6'(k);
        if (idx >= n) idx = idx - n;
        if (valid[idx[4:0]]) begin
          rr_pick = idx[4:0];
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Two-flop synchronizer bringing the destination's ack into the write domain.
module cdc_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic ack_async,
  output logic ack_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta     <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      meta     <= ack_async;
      ack_sync <= meta;
    end
  end

endmodule

// File: rtl/cdc_hs_src_arbiter.sv
// Round-robin arbiter feeding one 4-phase req/ack crossing; holds the winning
// payload stable until the destination has acknowledged and released.
module cdc_hs_src_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                      wr_clk,
  input  logic                      wr_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      xfer_req,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [IDW-1:0]            xfer_id,
  input  logic                      xfer_ack_async,
  output logic                      busy,
  input  logic                      err_clr,
  output logic                      timeout_err
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  hs_state_e            state;
  logic [IDW-1:0]       rr_ptr;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 ack_s;
  logic [4:0]           pick;
  logic [IDW-1:0]       grant;
  logic [IDW-1:0]       ptr_next;
  logic                 accept;
  logic                 state_chg;

  cdc_ack_sync u_ack_sync (
    .clk       (wr_clk),
    .reset     (wr_reset),
    .ack_async (xfer_ack_async),
    .ack_sync  (ack_s)
  );

  always_comb begin
    pick      = rr_pick(RR_MAX'(req_valid), 5'(rr_ptr), 6'(NUM_REQ));
    grant     = pick[IDW-1:0];
    ptr_next  = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    req_ready = '0;
    // A stale or glitching ack blocks new grants until it has gone low.
    if (state == HS_IDLE && !ack_s && |req_valid) req_ready[grant] = 1'b1;
    accept    = |(req_valid & req_ready);
    state_chg = (state == HS_IDLE && accept) ||
                (state == HS_REQ  && ack_s)  ||
                (state == HS_REL  && !ack_s);
  end

  assign busy = (state != HS_IDLE);

  always_ff @(posedge wr_clk) begin
    if (!wr_reset) begin
      state       <= HS_IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      xfer_id     <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: if (accept) begin
          xfer_data <= req_data[int'(grant)*DATA_W +: DATA_W];
          xfer_id   <= grant;
          rr_ptr    <= ptr_next;
          xfer_req  <= 1'b1;
          state     <= HS_REQ;
        end
        HS_REQ: if (ack_s) begin
          xfer_req <= 1'b0;
          state    <= HS_REL;
        end
        HS_REL: if (!ack_s) state <= HS_IDLE;
        default: begin
          xfer_req <= 1'b0;
          state    <= HS_IDLE;
        end
      endcase

      if (state_chg) wait_cnt <= '0;
      else if (state != HS_IDLE && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;

      // Fires once, on the cycle the counter reaches its ceiling, so a clear
      // issued while still stuck waiting is not immediately undone.
      if (!state_chg && state != HS_IDLE && wait_cnt == CNT_MAX - 1'b1)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_hs_src_arbiter.sv
// Directed bench for the CDC source-side arbiter; the bench acts as the
// destination domain by driving the raw ack directly.
module tb_cdc_hs_src_arbiter;

  logic        clk = 1'b0;
  logic        wr_reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        xfer_req;
  logic [7:0]  xfer_data;
  logic [1:0]  xfer_id;
  logic        xfer_ack_async;
  logic        busy;
  logic        err_clr;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  cdc_hs_src_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_W(4)) dut (
    .wr_clk         (clk),
    .wr_reset       (wr_reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_id        (xfer_id),
    .xfer_ack_async (xfer_ack_async),
    .busy           (busy),
    .err_clr        (err_clr),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    wr_reset = 1'b0;
    step();
    step();
    wr_reset = 1'b1;
  endtask

  task automatic wait_req(input string tag, input logic v);
    for (int i = 0; i < 40 && xfer_req !== v; i++) step();
    chk(tag, 32'(xfer_req), 32'(v));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic handshake(input string tag);
    xfer_ack_async = 1'b1;
    wait_req({tag, "_reqfall"}, 1'b0);
    xfer_ack_async = 1'b0;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    wr_reset = 1'b0; req_valid = '0; req_data = '0;
    xfer_ack_async = 1'b0; err_clr = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_req",   32'(xfer_req),    32'd0);
    chk("rst_data",  32'(xfer_data),   32'd0);
    chk("rst_id",    32'(xfer_id),     32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_err",   32'(timeout_err), 32'd0);
    chk("rst_ready", 32'(req_ready),   32'd0);

    // 1. Single request from requester 2
    req_valid = 4'b0100; req_data = 32'h00A5_0000;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("t1_req",  32'(xfer_req),  32'd1);
    chk("t1_data", 32'(xfer_data), 32'hA5);
    chk("t1_id",   32'(xfer_id),   32'd2);
    chk("t1_busy", 32'(busy),      32'd1);
    step(); step(); step();
    chk("t1_req_hold", 32'(xfer_req), 32'd1);
    xfer_ack_async = 1'b1;
    step(); step();
    chk("t1_req_sync", 32'(xfer_req), 32'd1);
    step();
    chk("t1_req_fall", 32'(xfer_req), 32'd0);
    chk("t1_rel_busy", 32'(busy),     32'd1);
    xfer_ack_async = 1'b0;
    step(); step();
    chk("t1_rel_hold", 32'(busy),      32'd1);
    chk("t1_rel_data", 32'(xfer_data), 32'hA5);
    step();
    chk("t1_done", 32'(busy), 32'd0);

    // 2. All four requesting continuously
    do_reset();
    req_valid = 4'b1111; req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      wait_req("t2_req", 1'b1);
      chk("t2_id",   32'(xfer_id),   32'(i % 4));
      chk("t2_data", 32'(xfer_data), 32'h10 + 32'(i % 4));
      handshake("t2");
    end
    req_valid = '0;
    step(); step();

    // 3. Wrap from rr_ptr=3 to requester 1, then pointer lands on 2
    do_reset();
    req_valid = 4'b0100; req_data = 32'h4433_2211;
    step();
    req_valid = '0;
    chk("t3_first_id", 32'(xfer_id), 32'd2);
    handshake("t3a");
    req_valid = 4'b0010;
    #1;
    chk("t3_wrap_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("t3_wrap_id",   32'(xfer_id),   32'd1);
    chk("t3_wrap_data", 32'(xfer_data), 32'h22);
    handshake("t3b");
    req_valid = 4'b1111;
    #1;
    chk("t3_ptr2", 32'(req_ready), 32'h4);
    req_valid = '0;
    step();

    // 4. Stale ack out of reset blocks grants until it clears
    xfer_ack_async = 1'b1;
    do_reset();
    step(); step();
    req_valid = 4'b0001; req_data = 32'h0000_00C3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_blocked", 32'(req_ready), 32'd0);
      step();
    end
    chk("t4_no_accept", 32'(busy), 32'd0);
    xfer_ack_async = 1'b0;
    step();
    chk("t4_still_blocked", 32'(req_ready), 32'd0);
    step();
    chk("t4_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("t4_id",   32'(xfer_id),   32'd0);
    chk("t4_data", 32'(xfer_data), 32'hC3);
    chk("t4_err",  32'(timeout_err), 32'd0);
    handshake("t4");

    // 5. Ack never returns: timeout at 15 cycles, set beats clear, late ack
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000_005A;
    step();
    req_valid = '0;
    for (int i = 0; i < 14; i++) step();
    chk("t5_no_err_yet", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    step();
    chk("t5_set_wins", 32'(timeout_err), 32'd1);
    chk("t5_req_held", 32'(xfer_req),    32'd1);
    step();
    chk("t5_cleared", 32'(timeout_err), 32'd0);
    err_clr = 1'b0;
    step(); step(); step();
    chk("t5_stays_clr", 32'(timeout_err), 32'd0);
    chk("t5_still_req", 32'(xfer_req),    32'd1);
    handshake("t5");
    chk("t5_final_data", 32'(xfer_data), 32'h5A);

    // 6. Reset in the middle of HS_REQ
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_7700;
    step();
    req_valid = '0;
    chk("t6_in_req", 32'(xfer_req), 32'd1);
    step();
    wr_reset = 1'b0;
    step();
    chk("t6_req",  32'(xfer_req),  32'd0);
    chk("t6_data", 32'(xfer_data), 32'd0);
    chk("t6_id",   32'(xfer_id),   32'd0);
    chk("t6_busy", 32'(busy),      32'd0);
    wr_reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t6_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
